// File: rtl/riscv_soft_axi_lite_master.sv
// riscv_soft_axi_lite_master
// Bridges the tile's ready/valid memory request port onto an AXI4-Lite
// master. One transaction at a time. Stores get lane-replicated data and
// byte strobes, and loads get lane extraction with sign/zero extension.
// Misaligned or illegal requests are answered with an error and never
// reach the bus.
module riscv_soft_axi_lite_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  MEM_LOAD   = 2'd1,
  parameter logic [1:0]  MEM_STORE  = 2'd2
) (
  input  logic                  clk,
  input  logic                  reset,
  // tile request / response port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [2:0]            req_op_type,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_error,
  // AXI4-Lite write address channel
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  // AXI4-Lite write data channel
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  // AXI4-Lite write response channel
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  // AXI4-Lite read data channel
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE            = 3'd0,
    S_WRITE_ADDR_DATA = 3'd1,
    S_WRITE_RESP      = 3'd2,
    S_READ_ADDR       = 3'd3,
    S_READ_DATA       = 3'd4,
    S_RESP            = 3'd5
  } state_t;

  // Replicate the right-aligned store data across every lane of its size,
  // so the strobe alone selects which bytes the slave writes.
  function automatic logic [31:0] lane_wdata(input logic [2:0] op_type,
                                             input logic [31:0] data);
    case (op_type)
      3'b000, 3'b100: lane_wdata = {4{data[7:0]}};
      3'b001, 3'b101: lane_wdata = {2{data[15:0]}};
      default:        lane_wdata = data;
    endcase
  endfunction

  // Byte strobe for the addressed lane(s).
  function automatic logic [3:0] lane_wstrb(input logic [2:0] op_type,
                                            input logic [1:0] offset);
    case (op_type)
      3'b000, 3'b100: lane_wstrb = 4'b0001 << offset;
      3'b001, 3'b101: lane_wstrb = 4'b0011 << offset;
      default:        lane_wstrb = 4'b1111;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0 and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [2:0] op_type,
                                               input logic [1:0] offset,
                                               input logic [31:0] rdata);
    logic [31:0] shifted;
    shifted = rdata >> {offset, 3'b000};
    case (op_type)
      3'b000:  load_extract = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_extract = {24'h000000, shifted[7:0]};
      3'b001:  load_extract = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_extract = {16'h0000, shifted[15:0]};
      default: load_extract = shifted;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [2:0]              op_type_q, op_type_d;
  logic [1:0]              offset_q, offset_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic                    aw_pend_q, aw_pend_d;
  logic                    w_pend_q, w_pend_d;
  logic                    error_q, error_d;
  logic [31:0]             resp_data_q, resp_data_d;

  logic                    req_op_bad;
  logic                    req_type_bad;
  logic                    req_misaligned;
  logic                    req_bad;
  logic                    req_is_store;

  assign req_op_bad   = (req_op != MEM_LOAD) && (req_op != MEM_STORE);
  assign req_is_store = (req_op == MEM_STORE);
  assign req_bad      = req_op_bad | req_type_bad | req_misaligned;

  // Classify the incoming funct3: legality and natural alignment.
  always_comb begin
    req_type_bad   = 1'b0;
    req_misaligned = 1'b0;
    case (req_op_type)
      3'b000, 3'b100: begin
        req_type_bad   = 1'b0;
        req_misaligned = 1'b0;
      end
      3'b001, 3'b101: begin
        req_type_bad   = 1'b0;
        req_misaligned = req_addr[0];
      end
      3'b010: begin
        req_type_bad   = 1'b0;
        req_misaligned = (req_addr[1:0] != 2'b00);
      end
      default: begin
        req_type_bad   = 1'b1;
        req_misaligned = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update for the single-transaction sequencer.
  always_comb begin
    state_d     = state_q;
    op_type_d   = op_type_q;
    offset_d    = offset_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    error_d     = error_q;
    resp_data_d = resp_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_type_d   = req_op_type;
          offset_d    = req_addr[1:0];
          addr_d      = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d     = lane_wdata(req_op_type, req_data);
          wstrb_d     = lane_wstrb(req_op_type, req_addr[1:0]);
          resp_data_d = 32'h0000_0000;
          error_d     = req_bad;
          if (req_bad) begin
            // Rejected up front: respond next cycle without touching the bus.
            state_d   = S_RESP;
            aw_pend_d = 1'b0;
            w_pend_d  = 1'b0;
          end else if (req_is_store) begin
            state_d   = S_WRITE_ADDR_DATA;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            state_d   = S_READ_ADDR;
            aw_pend_d = 1'b0;
            w_pend_d  = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WRITE_ADDR_DATA: begin
        // Each channel retires on its own handshake and is never re-raised.
        aw_pend_d = aw_pend_q & ~M_AXI_AWREADY;
        w_pend_d  = w_pend_q & ~M_AXI_WREADY;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = S_WRITE_RESP;
        end else begin
          state_d = S_WRITE_ADDR_DATA;
        end
      end

      S_WRITE_RESP: begin
        if (M_AXI_BVALID) begin
          error_d     = (M_AXI_BRESP != 2'b00);
          resp_data_d = 32'h0000_0000;
          state_d     = S_RESP;
        end else begin
          state_d = S_WRITE_RESP;
        end
      end

      S_READ_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = S_READ_DATA;
        end else begin
          state_d = S_READ_ADDR;
        end
      end

      S_READ_DATA: begin
        if (M_AXI_RVALID) begin
          error_d = (M_AXI_RRESP != 2'b00);
          if (M_AXI_RRESP != 2'b00) begin
            // SLVERR/DECERR: never hand partial data back to the tile.
            resp_data_d = 32'h0000_0000;
          end else begin
            resp_data_d = load_extract(op_type_q, offset_q, M_AXI_RDATA);
          end
          state_d = S_RESP;
        end else begin
          state_d = S_READ_DATA;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        aw_pend_d = 1'b0;
        w_pend_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_type_q   <= 3'b000;
      offset_q    <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      wstrb_q     <= 4'b0000;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      error_q     <= 1'b0;
      resp_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      op_type_q   <= op_type_d;
      offset_q    <= offset_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      error_q     <= error_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Every output is a register or a decode of the state register, so no
  // AXI input reaches an output (or a READY) combinationally.
  assign req_ready     = reset | (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_error    = (state_q == S_RESP) & error_q;
  assign resp_data     = resp_data_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_pend_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = w_pend_q;
  assign M_AXI_BREADY  = (state_q == S_WRITE_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state_q == S_READ_ADDR);
  assign M_AXI_RREADY  = (state_q == S_READ_DATA);

endmodule

// File: doc/riscv_soft_axi_lite_master.md
# riscv_soft_axi_lite_master

Bridges the RISC-V soft tile's host-style memory request port (ready/valid request, single-pulse response) onto an AXI4-Lite master interface, so tile-side requesters can reach AXI-Lite peripherals and memories. It handles one transaction at a time: byte, half and word loads/stores, write-strobe generation, read-lane extraction with sign/zero extension, and error reporting for misaligned accesses and non-OKAY bus responses.

## Interface
- `ADDR_WIDTH`, 32, width of `req_addr`, `M_AXI_AWADDR` and `M_AXI_ARADDR`; the data path is fixed at XPR_LEN = 32.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `req_valid` in 1 / `req_ready` out 1 — request handshake.
- `req_op`  in  2  `MEM_LOAD` or `MEM_STORE` from riscv_soft_constants.v; any other value is an error.
- `req_op_type`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other value is an error.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_data`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_data`  out  32  load result, extended; 0 for stores and errors.
- `resp_error`  out  1  qualified by `resp_valid`.
- `M_AXI_AWADDR/AWPROT/AWVALID/AWREADY`  out/out/out/in  ADDR_WIDTH/3/1/1.
- `M_AXI_WDATA/WSTRB/WVALID/WREADY`  out/out/out/in  32/4/1/1.
- `M_AXI_BRESP/BVALID/BREADY`  in/in/out  2/1/1.
- `M_AXI_ARADDR/ARPROT/ARVALID/ARREADY`  out/out/out/in  ADDR_WIDTH/3/1/1.
- `M_AXI_RDATA/RRESP/RVALID/RREADY`  in/in/in/out  32/2/1/1.

## Operation
- States: S_IDLE, S_WRITE_ADDR_DATA, S_WRITE_RESP, S_READ_ADDR, S_READ_DATA, S_RESP.
- S_IDLE:
  - `req_ready`=1.
  - On `req_valid`, capture op, op_type, addr[1:0], AXI address (addr with [1:0] cleared), lane-aligned data and strobe.
  - Illegal op, illegal op_type, or misalignment (H/HU with addr[0]=1, W with addr[1:0]≠0) → S_RESP with error set and no bus activity.
  - Otherwise a store goes to S_WRITE_ADDR_DATA and a load goes to S_READ_ADDR.
- Store lanes:
  - B: WDATA={4{d[7:0]}}, WSTRB=4'b0001<<a.
  - H: WDATA={2{d[15:0]}}, WSTRB=4'b0011<<a.
  - W: WDATA=d, WSTRB=4'hF.
- S_WRITE_ADDR_DATA:
  - AWVALID and WVALID rise together; each drops independently after its own handshake and neither is re-raised.
  - When both handshakes are done (same cycle or different cycles) → S_WRITE_RESP.
- S_WRITE_RESP: BREADY=1; on BVALID, latch error=(BRESP≠2'b00) → S_RESP.
- S_READ_ADDR: ARVALID=1; on ARREADY → S_READ_DATA.
- S_READ_DATA:
  - RREADY=1; on RVALID, select the lane RDATA>>(8*a).
  - Extension: B sign-extends bit 7, BU zero-extends, H sign-extends bit 15, HU zero-extends, W is unchanged.
  - Latch error=(RRESP≠2'b00) → S_RESP.
- S_RESP:
  - `resp_valid`=1 for exactly this cycle → S_IDLE.
  - `resp_data` is forced to 0 when error is set.
  - Read data is still returned on SLVERR/DECERR? No: it is zeroed.
- AWPROT = ARPROT = 3'b000 constantly.
- While a VALID is high, the payload on that channel is held stable.
- Unknown state encoding → S_IDLE.

## Timing
- Reset values:
  - state S_IDLE.
  - All outputs 0, except `req_ready`=1 during reset.
  - `resp_valid`, AWVALID, WVALID, ARVALID, BREADY and RREADY are 0 in the first cycle after reset.
- Reset mid-transaction:
  - The transaction is abandoned and all VALID/READY outputs drop the next cycle.
  - No response pulse is produced.
  - The system resets the AXI slave together with this block.
- Best case, with the slave always ready and responding the next cycle:
  - Accept in cycle N; AW/W (or AR) handshake at N+1; B (or R) at N+2; `resp_valid` at N+3; `req_ready` again at N+4.
- Error path for illegal or misaligned requests: accept at N, `resp_valid` at N+1.
- Only one outstanding transaction. `req_ready` is low from N+1 until return to S_IDLE.
- READY outputs never depend combinationally on the corresponding VALID inputs.
- `resp_*` are registered or derived from the state only; no combinational path from AXI inputs to `resp_*`.

## Test plan
- SW 0xDEADBEEF @0x100 with AWREADY=WREADY=1 and BRESP=00:
  - AWADDR=0x100, WSTRB=F, WDATA=0xDEADBEEF.
  - `resp_valid` at N+3, error=0.
- SB 0x5A @0x203 with AWREADY delayed 3 cycles and WREADY immediate:
  - WVALID drops after 1 cycle; AWVALID holds 3 cycles.
  - AWADDR=0x200, WSTRB=4'b1000, WDATA=0x5A5A5A5A; single response.
- LB vs LBU @0x102 with RDATA=0x00800000: LB → 0xFFFFFF80; LBU → 0x00000080; ARADDR=0x100.
- LH @0x102 with RDATA=0x8001_0000 and RRESP=2'b10: error=1, data=0.
- LW @0x101 (misaligned): no ARVALID ever; `resp_valid` at N+1, error=1.
- Reset asserted while AWVALID is high:
  - All valids 0 the next cycle, no `resp_valid`.
  - A following SW completes normally.
